// File: rtl/fx2_ep_scheduler.sv
// Endpoint scheduler for the FX2 slave-FIFO bus: picks EP2 / EP6 / EP4, settles FIFO_ADR,
// qualifies flags against local FIFO levels and hands one burst at a time to the bus engine.
module fx2_ep_scheduler #(
  parameter int unsigned RX_BURST_SZ   = 64,
  parameter int unsigned TX_BURST_SZ   = 256,
  parameter int unsigned SP_BURST_SZ   = 64,
  parameter int unsigned RFSZ          = 11,
  parameter int unsigned TFSZ          = 12,
  parameter int unsigned SFSZ          = 10,
  parameter int unsigned RX_HIGH_WATER = 1512,
  parameter int unsigned TX_WEIGHT     = 4,
  parameter int unsigned ADR_SETTLE    = 1,
  parameter int unsigned BUSY_TIMEOUT  = 4096,
  localparam int unsigned MAX_RT       = (RX_BURST_SZ > TX_BURST_SZ) ? RX_BURST_SZ : TX_BURST_SZ,
  localparam int unsigned MAX_BURST    = (MAX_RT > SP_BURST_SZ) ? MAX_RT : SP_BURST_SZ,
  localparam int unsigned LSZ          = $clog2(MAX_BURST + 1)
) (
  input  logic            IFCLK,
  input  logic            IF_rst,
  input  logic            FLAGA,
  input  logic            FLAGB,
  input  logic            FLAGC,
  input  logic [RFSZ-1:0] Rx_fifo_used,
  input  logic            Rx_fifo_full,
  input  logic [TFSZ-1:0] Tx_fifo_used,
  input  logic            Tx_fifo_full,
  input  logic [SFSZ-1:0] Sp_fifo_used,
  input  logic            Sp_fifo_full,
  output logic [1:0]      FIFO_ADR,
  output logic            xfer_start,
  output logic [1:0]      xfer_src,
  output logic            xfer_dir,
  output logic [LSZ-1:0]  xfer_len,
  input  logic            xfer_done,
  output logic            busy,
  output logic            err_timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_START = 3'd4;
  localparam logic [2:0] S_BUSY  = 3'd5;
  localparam logic [2:0] S_NEXT  = 3'd6;

  localparam logic [1:0] SRC_RX = 2'd0;
  localparam logic [1:0] SRC_TX = 2'd1;
  localparam logic [1:0] SRC_SP = 2'd2;

  localparam logic [1:0] ADR_EP2 = 2'b00;
  localparam logic [1:0] ADR_EP4 = 2'b01;
  localparam logic [1:0] ADR_EP6 = 2'b10;

  localparam int unsigned CW = $clog2(TX_WEIGHT + 1);
  localparam int unsigned SW = $clog2(ADR_SETTLE + 1);
  localparam int unsigned BW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [RFSZ:0]  RX_HW    = (RFSZ + 1)'(RX_HIGH_WATER);
  localparam logic [TFSZ:0]  TX_MIN   = (TFSZ + 1)'(TX_BURST_SZ);
  localparam logic [SFSZ:0]  SP_MIN   = (SFSZ + 1)'(SP_BURST_SZ);
  localparam logic [CW-1:0]  CRED_MAX = CW'(TX_WEIGHT);
  localparam logic [SW-1:0]  SETTLE_L = SW'(ADR_SETTLE - 1);
  localparam logic [BW-1:0]  BUSY_L   = BW'(BUSY_TIMEOUT - 1);

  logic [2:0]     state_q, state_d;
  logic           slot_q, slot_d;        // 0: RX slot, 1: to-PC slot
  logic           alt_q, alt_d;          // to-PC slot already fell back to the alternate
  logic [1:0]     cand_q, cand_d;
  logic [CW-1:0]  tx_credit_q, tx_credit_d;
  logic [SW-1:0]  settle_q, settle_d;
  logic [BW-1:0]  busy_cnt_q, busy_cnt_d;
  logic [1:0]     fifo_adr_q, fifo_adr_d;
  logic [1:0]     xfer_src_q, xfer_src_d;
  logic           xfer_dir_q, xfer_dir_d;
  logic [LSZ-1:0] xfer_len_q, xfer_len_d;
  logic           err_q, err_d;

  logic [RFSZ:0] rx_level;
  logic [TFSZ:0] tx_level;
  logic [SFSZ:0] sp_level;
  logic          rx_rdy, tx_rdy, sp_rdy, cand_rdy;
  logic [1:0]    primary, addr_cand, addr_adr;
  logic [LSZ-1:0] cand_len;

  // The full bit on top keeps a wrapped used count reading as maximum level.
  assign rx_level = {Rx_fifo_full, Rx_fifo_used};
  assign tx_level = {Tx_fifo_full, Tx_fifo_used};
  assign sp_level = {Sp_fifo_full, Sp_fifo_used};

  assign rx_rdy = FLAGA && (rx_level < RX_HW);
  assign tx_rdy = FLAGC && (tx_level >= TX_MIN);
  assign sp_rdy = FLAGB && (sp_level >= SP_MIN);

  assign primary   = (tx_credit_q != '0) ? SRC_TX : SRC_SP;
  assign addr_cand = alt_q ? cand_q : (slot_q ? primary : SRC_RX);

  always_comb begin
    addr_adr = ADR_EP2;
    case (addr_cand)
      SRC_TX:  addr_adr = ADR_EP6;
      SRC_SP:  addr_adr = ADR_EP4;
      default: addr_adr = ADR_EP2;
    endcase
  end

  always_comb begin
    cand_rdy = 1'b0;
    cand_len = LSZ'(RX_BURST_SZ);
    case (cand_q)
      SRC_TX: begin
        cand_rdy = tx_rdy;
        cand_len = LSZ'(TX_BURST_SZ);
      end
      SRC_SP: begin
        cand_rdy = sp_rdy;
        cand_len = LSZ'(SP_BURST_SZ);
      end
      default: begin
        cand_rdy = rx_rdy;
        cand_len = LSZ'(RX_BURST_SZ);
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    alt_d       = alt_q;
    cand_d      = cand_q;
    tx_credit_d = tx_credit_q;
    settle_d    = settle_q;
    busy_cnt_d  = busy_cnt_q;
    fifo_adr_d  = fifo_adr_q;
    xfer_src_d  = xfer_src_q;
    xfer_dir_d  = xfer_dir_q;
    xfer_len_d  = xfer_len_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: state_d = S_ADDR;
      S_ADDR: begin
        cand_d     = addr_cand;
        fifo_adr_d = addr_adr;
        settle_d   = SETTLE_L;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (settle_q == '0) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      S_CHECK: begin
        if (cand_rdy) begin
          xfer_src_d = cand_q;
          xfer_dir_d = (cand_q != SRC_RX);
          xfer_len_d = cand_len;
          state_d    = S_START;
        end else if (slot_q && !alt_q) begin
          alt_d   = 1'b1;
          cand_d  = (cand_q == SRC_TX) ? SRC_SP : SRC_TX;
          state_d = S_ADDR;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_START: begin
        busy_cnt_d = '0;
        state_d    = S_BUSY;
      end
      S_BUSY: begin
        if (xfer_done) begin
          state_d = S_NEXT;
          if (xfer_src_q == SRC_TX) begin
            if (tx_credit_q != '0) tx_credit_d = tx_credit_q - CW'(1);
          end else if (xfer_src_q == SRC_SP) begin
            tx_credit_d = CRED_MAX;
          end
        end else if (busy_cnt_q == BUSY_L) begin
          err_d   = 1'b1;
          state_d = S_NEXT;
        end else begin
          busy_cnt_d = busy_cnt_q + BW'(1);
        end
      end
      S_NEXT: begin
        slot_d  = ~slot_q;
        alt_d   = 1'b0;
        state_d = S_ADDR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge IFCLK or posedge IF_rst) begin
    if (IF_rst) begin
      state_q     <= S_IDLE;
      slot_q      <= 1'b0;
      alt_q       <= 1'b0;
      cand_q      <= SRC_RX;
      tx_credit_q <= CRED_MAX;
      settle_q    <= '0;
      busy_cnt_q  <= '0;
      fifo_adr_q  <= ADR_EP2;
      xfer_src_q  <= SRC_RX;
      xfer_dir_q  <= 1'b0;
      xfer_len_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      alt_q       <= alt_d;
      cand_q      <= cand_d;
      tx_credit_q <= tx_credit_d;
      settle_q    <= settle_d;
      busy_cnt_q  <= busy_cnt_d;
      fifo_adr_q  <= fifo_adr_d;
      xfer_src_q  <= xfer_src_d;
      xfer_dir_q  <= xfer_dir_d;
      xfer_len_q  <= xfer_len_d;
      err_q       <= err_d;
    end
  end

  assign FIFO_ADR    = fifo_adr_q;
  assign xfer_start  = (state_q == S_START);
  assign busy        = (state_q == S_START) || (state_q == S_BUSY);
  assign xfer_src    = xfer_src_q;
  assign xfer_dir    = xfer_dir_q;
  assign xfer_len    = xfer_len_q;
  assign err_timeout = err_q;

endmodule
